// File: rtl/nx_mimosa_v40_pkg.sv
// Shared Q16.16 fixed-point type and helpers for the v40 tracker datapath.
package nx_mimosa_v40_pkg;

    localparam int unsigned STATE_DIM = 4;
    localparam int unsigned FP_W      = 32;
    localparam int unsigned FP_FRAC   = 16;

    typedef logic signed [FP_W-1:0] fp_t;

    localparam fp_t FP_ZERO = fp_t'(32'sd0);
    localparam fp_t FP_ONE  = fp_t'(32'sd65536);
    localparam fp_t FP_EPS  = fp_t'(32'sd16);

    // Product floors toward -inf; inputs are full-range signed Q16.16.
    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic signed [2*FP_W-1:0] p;
        p = (2*FP_W)'(a) * (2*FP_W)'(b);
        return fp_t'(p >>> FP_FRAC);
    endfunction

    // Quotient truncates toward zero; a zero divisor yields zero rather than X.
    function automatic fp_t fp_div(input fp_t a, input fp_t b);
        logic signed [2*FP_W-1:0] n;
        logic signed [2*FP_W-1:0] d;
        if (b == FP_ZERO) begin
            return FP_ZERO;
        end
        n = (2*FP_W)'(a) <<< FP_FRAC;
        d = (2*FP_W)'(b);
        return fp_t'(n / d);
    endfunction

endpackage

// File: rtl/nx_mimosa_v40_smooth_fuse.sv
// Per-track mu-weighted fusion of N_MODELS smoothed lane states into a valid/ready FIFO.
// Optional statistics counters: define NX_MIMOSA_SMOOTH_FUSE_STATS_EN.
module nx_mimosa_v40_smooth_fuse
    import nx_mimosa_v40_pkg::*;
#(
    parameter int unsigned N_MODELS       = 3,
    parameter int unsigned TIMEOUT_CYC    = 4096,
    parameter int unsigned OUT_FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_MODELS-1:0]                   in_valid,
    input  fp_t  [N_MODELS-1:0][STATE_DIM-1:0]    in_x,
    input  fp_t  [N_MODELS-1:0]                   in_quality,
    input  fp_t  [N_MODELS-1:0]                   in_mu,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output fp_t  [STATE_DIM-1:0]                  out_x,
    output fp_t                                   out_quality,
    output logic [N_MODELS-1:0]                   out_mask,
    output logic [1:0]                            out_flags,
    output logic [1:0]                            err_sticky,
    output logic [15:0]                           stat_epochs,
    output logic [15:0]                           stat_timeouts,
    output logic [15:0]                           stat_drops
);

    localparam int unsigned TMR_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned AW     = $clog2(OUT_FIFO_DEPTH);
    localparam int unsigned LANE_W = (N_MODELS > 1) ? $clog2(N_MODELS) : 1;
    localparam int unsigned DIM_W  = (STATE_DIM > 1) ? $clog2(STATE_DIM) : 1;
    localparam int unsigned IDX_N  = (N_MODELS > STATE_DIM + 1) ? N_MODELS : STATE_DIM + 1;
    localparam int unsigned IDX_W  = $clog2(IDX_N);
    localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [N_MODELS-1:0] ALL_LANES = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_NORM, S_PUSH} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q;
    logic                   load, acc_en, norm_en, push;

    logic [N_MODELS-1:0]    got;
    logic [TMR_W-1:0]       timer;
    logic                   complete_q;
    logic                   got_full, timeout_hit;
    fp_t  [N_MODELS-1:0][STATE_DIM-1:0] cap_x;
    fp_t  [N_MODELS-1:0]    cap_q, cap_mu;

    fp_t  [N_MODELS-1:0][STATE_DIM-1:0] w_x;
    fp_t  [N_MODELS-1:0]    w_q, w_mu;
    logic [N_MODELS-1:0]    w_mask;
    logic                   w_to;
    fp_t  [STATE_DIM-1:0]   acc_x, res_x;
    fp_t                    acc_q, acc_mu, res_q;
    logic [LANE_W-1:0]      lane, low_lane;
    logic [DIM_W-1:0]       dim;
    logic                   is_q_step, degen;
    fp_t                    norm_val;

    fp_t  [STATE_DIM-1:0]   fifo_x     [OUT_FIFO_DEPTH];
    fp_t                    fifo_q     [OUT_FIFO_DEPTH];
    logic [N_MODELS-1:0]    fifo_mask  [OUT_FIFO_DEPTH];
    logic [1:0]             fifo_flags [OUT_FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count, count_d;
    logic                   pop, full, push_ok, drop;

    // Collector: epoch completes on all lanes present or timer expiry; registered one cycle.
    assign got_full    = (got == ALL_LANES);
    assign timeout_hit = (got != '0) && !got_full && (timer == TMR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got        <= '0;
            timer      <= '0;
            complete_q <= 1'b0;
            cap_x      <= '0;
            cap_q      <= '0;
            cap_mu     <= '0;
        end else begin
            for (int m = 0; m < N_MODELS; m++) begin
                if (in_valid[m]) begin
                    cap_x[m]  <= in_x[m];
                    cap_q[m]  <= in_quality[m];
                    cap_mu[m] <= in_mu[m][FP_W-1] ? FP_ZERO : in_mu[m];
                end
            end
            if (load) begin
                got        <= in_valid;
                timer      <= '0;
                complete_q <= 1'b0;
            end else begin
                got <= got | in_valid;
                if (got == '0) begin
                    timer <= '0;
                end else if (!got_full && timer != TMR_LAST) begin
                    timer <= timer + 1'b1;
                end
                if (got_full || timeout_hit) begin
                    complete_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= (state_d != state_q || state_q == S_IDLE) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (complete_q) state_d = S_ACCUM;
            S_ACCUM: if (idx_q == IDX_W'(N_MODELS - 1)) state_d = S_NORM;
            S_NORM:  if (idx_q == IDX_W'(STATE_DIM)) state_d = S_PUSH;
            S_PUSH:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        acc_en  = 1'b0;
        norm_en = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE:  load    = complete_q;
            S_ACCUM: acc_en  = 1'b1;
            S_NORM:  norm_en = 1'b1;
            S_PUSH:  push    = 1'b1;
            default: ;
        endcase
    end

    assign lane      = LANE_W'(idx_q);
    assign dim       = DIM_W'(idx_q);
    assign is_q_step = (idx_q == IDX_W'(STATE_DIM));
    assign degen     = (acc_mu <= FP_EPS);

    // Fallback lane when the weights carry no information.
    always_comb begin
        low_lane = '0;
        for (int m = N_MODELS - 1; m >= 0; m--) begin
            if (w_mask[m]) low_lane = LANE_W'(m);
        end
    end

    always_comb begin
        norm_val = FP_ZERO;
        if (is_q_step) begin
            norm_val = degen ? w_q[low_lane] : fp_div(acc_q, acc_mu);
        end else begin
            norm_val = degen ? w_x[low_lane][dim] : fp_div(acc_x[dim], acc_mu);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_x    <= '0;
            w_q    <= '0;
            w_mu   <= '0;
            w_mask <= '0;
            w_to   <= 1'b0;
            acc_x  <= '0;
            acc_q  <= FP_ZERO;
            acc_mu <= FP_ZERO;
            res_x  <= '0;
            res_q  <= FP_ZERO;
        end else begin
            if (load) begin
                w_x    <= cap_x;
                w_q    <= cap_q;
                w_mu   <= cap_mu;
                w_mask <= got;
                w_to   <= !got_full;
                acc_x  <= '0;
                acc_q  <= FP_ZERO;
                acc_mu <= FP_ZERO;
            end
            if (acc_en && w_mask[lane]) begin
                for (int i = 0; i < STATE_DIM; i++) begin
                    acc_x[i] <= acc_x[i] + fp_mul(w_mu[lane], w_x[lane][i]);
                end
                acc_q  <= acc_q + fp_mul(w_mu[lane], w_q[lane]);
                acc_mu <= acc_mu + w_mu[lane];
            end
            if (norm_en) begin
                if (is_q_step) res_q <= norm_val;
                else           res_x[dim] <= norm_val;
            end
        end
    end

    // Output FIFO; a push into a full FIFO survives only if the head pops that cycle.
    assign pop     = out_valid && out_ready;
    assign full    = (count == (AW+1)'(OUT_FIFO_DEPTH));
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign count_d = count + (AW+1)'(push_ok) - (AW+1)'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < OUT_FIFO_DEPTH; k++) begin
                fifo_x[k]     <= '0;
                fifo_q[k]     <= FP_ZERO;
                fifo_mask[k]  <= '0;
                fifo_flags[k] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_x[wr_ptr]     <= res_x;
                fifo_q[wr_ptr]     <= res_q;
                fifo_mask[wr_ptr]  <= w_mask;
                fifo_flags[wr_ptr] <= {degen, w_to};
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count_d;
            out_valid <= (count_d != '0);
        end
    end

    assign out_x       = fifo_x[rd_ptr];
    assign out_quality = fifo_q[rd_ptr];
    assign out_mask    = fifo_mask[rd_ptr];
    assign out_flags   = fifo_flags[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= '0;
        end else begin
            if (drop) err_sticky[0] <= 1'b1;
            if (|(in_valid & got) && !load) err_sticky[1] <= 1'b1;
        end
    end

`ifdef NX_MIMOSA_SMOOTH_FUSE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_epochs   <= '0;
            stat_timeouts <= '0;
            stat_drops    <= '0;
        end else begin
            if (push && stat_epochs != 16'hFFFF) stat_epochs <= stat_epochs + 1'b1;
            if (push && w_to && stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 1'b1;
            if (drop && stat_drops != 16'hFFFF) stat_drops <= stat_drops + 1'b1;
        end
    end
`else
    assign stat_epochs   = '0;
    assign stat_timeouts = '0;
    assign stat_drops    = '0;
`endif

endmodule
